// File: rtl/data_rx.sv
// Serial-to-parallel byte receiver: hunts for SYNC_BYTE, then emits one aligned byte every 8 bit clocks.
// Optional lock-loss statistics counter enabled by defining DATA_RX_STATS_EN.
module data_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hBC,
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic       clk_400MHz,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       is_sync,
  output logic       locked
`ifdef DATA_RX_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [15:0] TIMEOUT_W  = 16'(SYNC_TIMEOUT);
  localparam bit          TIMEOUT_EN = (SYNC_TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] since_q, since_d;
  logic [15:0] since_inc;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        is_sync_q, is_sync_d;
  logic        locked_q, locked_d;
  logic        timeout_evt;
  logic [7:0]  w;

  always_comb begin
    w           = {sr_q[6:0], data_in};
    sr_d        = w;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    since_d     = since_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    is_sync_d   = is_sync_q;
    locked_d    = locked_q;
    timeout_evt = 1'b0;
    since_inc   = (since_q == 16'hFFFF) ? since_q : since_q + 16'd1;

    case (state_q)
      HUNT: begin
        if (w == SYNC_BYTE) begin
          state_d    = LOCKED;
          bit_cnt_d  = 3'd0;
          since_d    = 16'd0;
          data_out_d = w;
          valid_d    = 1'b1;
          is_sync_d  = 1'b1;
          locked_d   = 1'b1;
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        // Only the byte boundary is examined; off-boundary sync patterns never realign.
        if (bit_cnt_q == 3'd7) begin
          data_out_d = w;
          valid_d    = 1'b1;
          is_sync_d  = (w == SYNC_BYTE);
          if (w == SYNC_BYTE) begin
            since_d = 16'd0;
          end else begin
            since_d = since_inc;
            if (TIMEOUT_EN && (since_inc == TIMEOUT_W)) begin
              timeout_evt = 1'b1;
              state_d     = HUNT;
              locked_d    = 1'b0;
              bit_cnt_d   = 3'd0;
              since_d     = 16'd0;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_400MHz) begin
    if (reset) begin
      state_q    <= HUNT;
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      since_q    <= 16'd0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      is_sync_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      since_q    <= since_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      is_sync_q  <= is_sync_d;
      locked_q   <= locked_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign is_sync    = is_sync_q;
  assign locked     = locked_q;

`ifdef DATA_RX_STATS_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (timeout_evt && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clk_400MHz) begin
    if (reset) loss_q <= 8'h00;
    else       loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`else
  logic unused_timeout_evt;
  assign unused_timeout_evt = timeout_evt;
`endif

endmodule

// File: tb/tb_data_rx.sv
// Directed bench for data_rx: three instances (timeout 16, 4, 0) driven one at a time,
// scoreboard of expected strobes {dut, cycle, locked, is_sync, data} checked by a monitor.
module tb_data_rx;

  logic clk_400MHz = 1'b0;
  always #5 clk_400MHz = ~clk_400MHz;

  logic       reset;
  logic       din_a, din_b, din_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic       dv_a, dv_b, dv_c;
  logic       sync_a, sync_b, sync_c;
  logic       lock_a, lock_b, lock_c;
`ifdef DATA_RX_STATS_EN
  logic [7:0] loss_a, loss_b, loss_c;
`endif

  data_rx #(.SYNC_BYTE(8'hBC), .SYNC_TIMEOUT(16)) dut_a (
    .clk_400MHz(clk_400MHz), .reset(reset), .data_in(din_a),
    .data_out(dout_a), .data_valid(dv_a), .is_sync(sync_a), .locked(lock_a)
`ifdef DATA_RX_STATS_EN
    , .lock_loss_cnt(loss_a)
`endif
  );

  data_rx #(.SYNC_BYTE(8'hBC), .SYNC_TIMEOUT(4)) dut_b (
    .clk_400MHz(clk_400MHz), .reset(reset), .data_in(din_b),
    .data_out(dout_b), .data_valid(dv_b), .is_sync(sync_b), .locked(lock_b)
`ifdef DATA_RX_STATS_EN
    , .lock_loss_cnt(loss_b)
`endif
  );

  data_rx #(.SYNC_BYTE(8'hBC), .SYNC_TIMEOUT(0)) dut_c (
    .clk_400MHz(clk_400MHz), .reset(reset), .data_in(din_c),
    .data_out(dout_c), .data_valid(dv_c), .is_sync(sync_c), .locked(lock_c)
`ifdef DATA_RX_STATS_EN
    , .lock_loss_cnt(loss_c)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // entry layout: {dut_id[1:0], cycle[31:0], locked, is_sync, data[7:0]}
  logic [43:0] exp_q[$];

  always @(posedge clk_400MHz) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic l, input logic s, input logic [7:0] d);
    exp_q.push_back({id, cyc, l, s, d});
  endtask

  task automatic mon_one(input logic [1:0] id, input logic v, input logic [7:0] d,
                         input logic s, input logic l);
    logic [43:0] e;
    logic [43:0] a;
    if (v) begin
      total++;
      a = {id, cyc, l, s, d};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe: dut%0d unexpected at cyc=%0d data=%h sync=%b locked=%b, want no strobe",
                 id, cyc, d, s, l);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL strobe: got dut%0d cyc=%0d locked=%b sync=%b data=%h, want dut%0d cyc=%0d locked=%b sync=%b data=%h",
                   a[43:42], a[41:10], a[9], a[8], a[7:0], e[43:42], e[41:10], e[9], e[8], e[7:0]);
        end
      end
    end
  endtask

  always @(negedge clk_400MHz) begin
    mon_one(2'd0, dv_a, dout_a, sync_a, lock_a);
    mon_one(2'd1, dv_b, dout_b, sync_b, lock_b);
    mon_one(2'd2, dv_c, dout_c, sync_c, lock_c);
  end

  // ---------------- drivers ----------------
  task automatic send_bit(input int id, input logic b);
    case (id)
      0:       din_a = b;
      1:       din_b = b;
      default: din_c = b;
    endcase
    @(posedge clk_400MHz);
    #1;
  endtask

  task automatic send_byte(input int id, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(id, v[i]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout_a"}, {24'd0, dout_a}, 32'd0);
    chk({tag, "_dv_a"},   {31'd0, dv_a},   32'd0);
    chk({tag, "_sync_a"}, {31'd0, sync_a}, 32'd0);
    chk({tag, "_lock_a"}, {31'd0, lock_a}, 32'd0);
    chk({tag, "_dout_b"}, {24'd0, dout_b}, 32'd0);
    chk({tag, "_lock_b"}, {31'd0, lock_b}, 32'd0);
    chk({tag, "_lock_c"}, {31'd0, lock_c}, 32'd0);
`ifdef DATA_RX_STATS_EN
    chk({tag, "_loss_b"}, {24'd0, loss_b}, 32'd0);
`endif
  endtask

  task automatic apply_reset(input string tag);
    din_a = 1'b0;
    din_b = 1'b0;
    din_c = 1'b0;
    reset = 1'b1;
    @(posedge clk_400MHz);
    #1;
    reset = 1'b0;
    chk_reset_outputs(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    reset = 1'b1;
    din_a = 1'b0;
    din_b = 1'b0;
    din_c = 1'b0;
    repeat (2) @(posedge clk_400MHz);
    #1;
    apply_reset("rst0");

    // first lock: sync byte straight after reset
    send_byte(0, 8'hBC); push(2'd0, 1'b1, 1'b1, 8'hBC);

    // data bytes; 0x0B,0xC0 hide an off-boundary 0xBC that must be ignored
    send_byte(0, 8'h5A); push(2'd0, 1'b1, 1'b0, 8'h5A);
    send_byte(0, 8'hC3); push(2'd0, 1'b1, 1'b0, 8'hC3);
    send_byte(0, 8'h0B); push(2'd0, 1'b1, 1'b0, 8'h0B);
    send_byte(0, 8'hC0); push(2'd0, 1'b1, 1'b0, 8'hC0);
    send_bit(0, 1'b0);
    chk("lock_held_a", {31'd0, lock_a}, 32'd1);

    // alignment taken from sync after 3 leading junk bits
    apply_reset("rst1");
    send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b0);
    send_byte(0, 8'hBC); push(2'd0, 1'b1, 1'b1, 8'hBC);
    send_byte(0, 8'h81); push(2'd0, 1'b1, 1'b0, 8'h81);

    // reset three bits into a byte, no strobe at old boundary, relock
    send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b0);
    din_a = 1'b1;
    reset = 1'b1;
    @(posedge clk_400MHz);
    #1;
    reset = 1'b0;
    chk("midrst_dout_a", {24'd0, dout_a}, 32'd0);
    chk("midrst_dv_a",   {31'd0, dv_a},   32'd0);
    chk("midrst_sync_a", {31'd0, sync_a}, 32'd0);
    chk("midrst_lock_a", {31'd0, lock_a}, 32'd0);
    send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b0);
    send_byte(0, 8'hBC); push(2'd0, 1'b1, 1'b1, 8'hBC);

    // timeout of 4 on dut_b; an intermediate sync restarts the count
    apply_reset("rst2");
    send_byte(1, 8'hBC); push(2'd1, 1'b1, 1'b1, 8'hBC);
    send_byte(1, 8'h11); push(2'd1, 1'b1, 1'b0, 8'h11);
    send_byte(1, 8'h22); push(2'd1, 1'b1, 1'b0, 8'h22);
    send_byte(1, 8'h33); push(2'd1, 1'b1, 1'b0, 8'h33);
    send_byte(1, 8'hBC); push(2'd1, 1'b1, 1'b1, 8'hBC);
    send_byte(1, 8'h11); push(2'd1, 1'b1, 1'b0, 8'h11);
    send_byte(1, 8'h22); push(2'd1, 1'b1, 1'b0, 8'h22);
    send_byte(1, 8'h33); push(2'd1, 1'b1, 1'b0, 8'h33);
    send_byte(1, 8'h44); push(2'd1, 1'b0, 1'b0, 8'h44);
    chk("timeout_lock_b", {31'd0, lock_b}, 32'd0);
`ifdef DATA_RX_STATS_EN
    chk("timeout_loss_b", {24'd0, loss_b}, 32'd1);
`endif
    send_byte(1, 8'h00);
    send_byte(1, 8'h00);
    chk("hunt_lock_b", {31'd0, lock_b}, 32'd0);
    send_byte(1, 8'hBC); push(2'd1, 1'b1, 1'b1, 8'hBC);
    chk("relock_b", {31'd0, lock_b}, 32'd1);

    // timeout disabled on dut_c: 300 bytes keep lock
    apply_reset("rst3");
    send_byte(2, 8'hBC); push(2'd2, 1'b1, 1'b1, 8'hBC);
    for (int i = 0; i < 300; i++) begin
      v = 8'(i * 37 + 5);
      send_byte(2, v); push(2'd2, 1'b1, (v == 8'hBC), v);
    end
    chk("notimeout_lock_c", {31'd0, lock_c}, 32'd1);

    apply_reset("rst4");
    repeat (3) @(posedge clk_400MHz);
    #1;
    chk("queue_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
